ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Single-port RAM access controller shared by the instruction-fetch path and the load/store data path. Arbitrates between the two requesters and drives the RAM MFA/MFC handshake (address, direction, data size, write data). Captures read data and returns a one-cycle completion or error pulse to the winning requester. Enforces alignment checks and an MFC timeout, so a stalled RAM cannot hang the control unit.

## Interface
- ADDR_W, 9: RAM address width.
- TIMEOUT, 16: maximum ACCESS cycles without ramMFC before error (≥2).

- Clk  in  1  clock; all registers update on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ifReq  in  1  fetch request (level, held until ifGnt).
- ifAddr  in  ADDR_W  fetch address (word access, always read).
- ifGnt / ifDone / ifErr  out  1  grant / completion / error pulses to fetch.
- dReq  in  1  data request (level, held until dGnt).
- dRW  in  1  0=read, 1=write.
- dSize  in  2  11=word, 01=halfword, 00=byte, 10=reserved.
- dAddr  in  ADDR_W  data address.
- dWdata  in  32  store data.
- dGnt / dDone / dErr  out  1  grant / completion / error pulses to data path.
- rdata  out  32  last read data, valid from the Done pulse until the next read completes.
- ramMFA  out  1  memory function active.
- ramRW  out  1  0=read, 1=write.
- ramAddress  out  ADDR_W  latched address.
- ramDataSize  out  2  latched size.
- ramDataIn  out  32  latched write data.
- ramMFC  in  1  memory function complete.
- ramDataOut  in  32  RAM read data.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ACCESS, DONE, ERR. Reset: IDLE; all outputs 0; rdata=0; ramDataSize=00; cycle counter=0; lastGrant=DATA (fetch wins the first tie).
- IDLE, no request: stay.
- IDLE, one request: grant it.
- IDLE, both requests: grant the requester not in lastGrant. Alternate while both stay asserted.
- On grant:
  - Pulse xGnt for one cycle and update lastGrant.
  - Latch address, RW, size, and write data into ram* output registers.
  - Fetch always uses RW=0 and size=11.
- Alignment check at grant. The request is misaligned if:
  - size=11 and addr[1:0]≠0; or
  - size=01 and addr[0]≠0; or
  - size=10.
- Misaligned request: go to ERR. ramMFA is never asserted.
- Aligned request: go to ACCESS and clear the counter.
- ACCESS: ramMFA=1; ram* outputs held constant.
  - ramMFC=1: if the access is a read, rdata←ramDataOut. Go to DONE.
  - ramMFC=0 and counter=TIMEOUT-1: go to ERR.
  - Otherwise: counter+1.
- DONE: ramMFA=0; pulse the owner's xDone for one cycle; go to IDLE.
- ERR: ramMFA=0; pulse the owner's xErr for one cycle; rdata unchanged; go to IDLE.
- Write completion leaves rdata unchanged.
- A request deasserted before grant is withdrawn with no side effects. A request still asserted in the cycle after Done is a new request.
- ramMFC is ignored outside ACCESS, including a late MFC after timeout.
- Reset asserted mid-access:
  - Immediate IDLE; ramMFA and all pulses drop asynchronously.
  - No Done or Err is issued; the pending transfer is abandoned.

## Timing
- Grant to ramMFA rise: 1 cycle. ramMFA goes high in the cycle after xGnt.
- ramMFC in ACCESS cycle k: xDone is high in cycle k+1, rdata is valid in the same cycle, ramMFA is low.
- Minimum request-to-Done time is 3 cycles: IDLE (grant), ACCESS (MFC present), DONE.
- Back-to-back throughput: one access per 3 cycles plus RAM wait.
- Timeout: ramMFA stays high for exactly TIMEOUT cycles, then xErr pulses in the next cycle.
- Misaligned request: xErr pulses the cycle after xGnt.
- ramAddress, ramRW, ramDataSize and ramDataIn change only on grant. They hold their values through DONE and ERR until the next grant.
- Gnt, Done and Err are single-cycle pulses and mutually exclusive per cycle. At most one requester sees activity per cycle.

## Test plan
- Fetch only: ifReq, ifAddr=0x004, MFC after 2 ACCESS cycles, ramDataOut=0x2401000A. Expect ramRW=0, ramDataSize=11, ifDone 4 cycles after ifGnt, rdata=0x2401000A.
- Simultaneous ifReq and dReq held for 4 accesses, MFC immediate. Expect grants in order fetch, data, fetch, data; each Done 2 cycles after its Gnt.
- Data write: dRW=1, dSize=01, dAddr=0x102, dWdata=0x0000BEEF, MFC immediate. Expect ramRW=1, ramDataSize=01, ramDataIn=0x0000BEEF, dDone asserted, rdata unchanged.
- Misaligned word read at dAddr=0x003, and a second request with dSize=10. Expect dErr the cycle after dGnt, ramMFA never asserted.
- MFC never arrives, TIMEOUT=16. Expect ramMFA high exactly 16 cycles, then one dErr pulse. An MFC arriving afterwards is ignored and busy=0.
- Reset mid-ACCESS. Expect ramMFA=0 without waiting for a clock edge and no Done or Err. After release, ifReq is granted with fetch priority (lastGrant=DATA).

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Single-port RAM controller shared by instruction fetch and load/store data paths.
// Round-robin arbitration, MFA/MFC handshake, alignment check and MFC timeout.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifGnt,
  output logic              ifDone,
  output logic              ifErr,
  input  logic              dReq,
  input  logic              dRW,
  input  logic [1:0]        dSize,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [31:0]       dWdata,
  output logic              dGnt,
  output logic              dDone,
  output logic              dErr,
  output logic [31:0]       rdata,
  output logic              ramMFA,
  output logic              ramRW,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [1:0]        ramDataSize,
  output logic [31:0]       ramDataIn,
  input  logic              ramMFC,
  input  logic [31:0]       ramDataOut,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

  state_e            r_state;
  logic              r_last_data;
  logic              r_owner_data;
  logic [CntW-1:0]   r_cnt;
  logic [31:0]       r_rdata;
  logic              r_mfa;
  logic              r_if_done, r_if_err, r_d_done, r_d_err;
  logic              r_ram_rw;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [1:0]        r_ram_size;
  logic [31:0]       r_ram_din;

  logic              w_pick_if, w_pick_d, w_in_idle;
  logic [ADDR_W-1:0] w_req_addr;
  logic [1:0]        w_req_size;
  logic              w_req_rw;
  logic [31:0]       w_req_din;
  logic              w_misaligned;

  // Fetch wins a tie unless it was the last one granted.
  assign w_pick_if = ifReq & (~dReq | r_last_data);
  assign w_pick_d  = dReq & ~w_pick_if;
  assign w_in_idle = (r_state == StIdle) & ~reset;

  assign w_req_addr = w_pick_if ? ifAddr : dAddr;
  assign w_req_size = w_pick_if ? 2'b11 : dSize;
  assign w_req_rw   = w_pick_if ? 1'b0 : dRW;
  assign w_req_din  = w_pick_if ? 32'h0 : dWdata;

  always_comb begin
    w_misaligned = 1'b0;
    unique case (w_req_size)
      2'b11:   w_misaligned = (w_req_addr[1:0] != 2'b00);
      2'b01:   w_misaligned = w_req_addr[0];
      2'b10:   w_misaligned = 1'b1;
      default: w_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_last_data  <= 1'b1;
      r_owner_data <= 1'b0;
      r_cnt        <= '0;
      r_rdata      <= 32'h0;
      r_mfa        <= 1'b0;
      r_if_done    <= 1'b0;
      r_if_err     <= 1'b0;
      r_d_done     <= 1'b0;
      r_d_err      <= 1'b0;
      r_ram_rw     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_size   <= 2'b00;
      r_ram_din    <= 32'h0;
    end else begin
      r_if_done <= 1'b0;
      r_if_err  <= 1'b0;
      r_d_done  <= 1'b0;
      r_d_err   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (ifReq | dReq) begin
            r_last_data  <= w_pick_d;
            r_owner_data <= w_pick_d;
            r_ram_rw     <= w_req_rw;
            r_ram_addr   <= w_req_addr;
            r_ram_size   <= w_req_size;
            r_ram_din    <= w_req_din;
            r_cnt        <= '0;
            if (w_misaligned) begin
              r_state  <= StErr;
              r_if_err <= w_pick_if;
              r_d_err  <= w_pick_d;
            end else begin
              r_state <= StAccess;
              r_mfa   <= 1'b1;
            end
          end
        end
        StAccess: begin
          if (ramMFC) begin
            if (!r_ram_rw) r_rdata <= ramDataOut;
            r_state   <= StDone;
            r_mfa     <= 1'b0;
            r_if_done <= ~r_owner_data;
            r_d_done  <= r_owner_data;
          end else if (r_cnt == CntMax) begin
            r_state  <= StErr;
            r_mfa    <= 1'b0;
            r_if_err <= ~r_owner_data;
            r_d_err  <= r_owner_data;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone:  r_state <= StIdle;
        StErr:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ifGnt       = w_in_idle & w_pick_if;
  assign dGnt        = w_in_idle & w_pick_d;
  assign ifDone      = r_if_done;
  assign ifErr       = r_if_err;
  assign dDone       = r_d_done;
  assign dErr        = r_d_err;
  assign rdata       = r_rdata;
  assign ramMFA      = r_mfa;
  assign ramRW       = r_ram_rw;
  assign ramAddress  = r_ram_addr;
  assign ramDataSize = r_ram_size;
  assign ramDataIn   = r_ram_din;
  assign busy        = (r_state != StIdle);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: per-cycle vector table plus timeout and
// mid-access reset sequences.
module tb_ram_port_arbiter;

  logic        Clk, reset;
  logic        ifReq, dReq, dRW, ramMFC;
  logic [8:0]  ifAddr, dAddr, ramAddress;
  logic [1:0]  dSize, ramDataSize;
  logic [31:0] dWdata, ramDataOut, rdata, ramDataIn;
  logic        ifGnt, ifDone, ifErr, dGnt, dDone, dErr, ramMFA, ramRW, busy;
  logic [5:0]  pulses;

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(.ADDR_W(9), .TIMEOUT(16)) dut (
    .Clk(Clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifDone(ifDone), .ifErr(ifErr),
    .dReq(dReq), .dRW(dRW), .dSize(dSize), .dAddr(dAddr), .dWdata(dWdata),
    .dGnt(dGnt), .dDone(dDone), .dErr(dErr), .rdata(rdata),
    .ramMFA(ramMFA), .ramRW(ramRW), .ramAddress(ramAddress), .ramDataSize(ramDataSize),
    .ramDataIn(ramDataIn), .ramMFC(ramMFC), .ramDataOut(ramDataOut), .busy(busy)
  );

  assign pulses = {ifGnt, ifDone, ifErr, dGnt, dDone, dErr};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [5:0] PN = 6'b000000, PIG = 6'b100000, PID = 6'b010000, PIE = 6'b001000;
  localparam logic [5:0] PDG = 6'b000100, PDD = 6'b000010, PDE = 6'b000001;

  typedef struct {
    logic        ir;
    logic [8:0]  ia;
    logic        dr;
    logic        drw;
    logic [1:0]  dsz;
    logic [8:0]  da;
    logic [31:0] dwd;
    logic        mfc;
    logic [31:0] dout;
    logic [5:0]  pulse;
    logic        mfa;
    logic        bsy;
    logic [31:0] rd;
    logic        chk_ram;
    logic        rw;
    logic [1:0]  sz;
    logic [8:0]  addr;
    logic [31:0] din;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ir, input logic [8:0] ia, input logic dr, input logic drw,
                     input logic [1:0] dsz, input logic [8:0] da, input logic [31:0] dwd,
                     input logic mfc, input logic [31:0] dout, input logic [5:0] pulse,
                     input logic mfa, input logic bsy, input logic [31:0] rd,
                     input logic chk_ram, input logic rw, input logic [1:0] sz,
                     input logic [8:0] addr, input logic [31:0] din);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.drw = drw; v.dsz = dsz; v.da = da; v.dwd = dwd;
    v.mfc = mfc; v.dout = dout; v.pulse = pulse; v.mfa = mfa; v.bsy = bsy; v.rd = rd;
    v.chk_ram = chk_ram; v.rw = rw; v.sz = sz; v.addr = addr; v.din = din;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    bit seen;
    bit prev_mfa;
    int mfa_cnt;

    // Tie alternation (from reset), fetch read with wait states, data write, misaligned.
    add(1,9'h010,1,0,2'b11,9'h020,0, 0,0,            PIG,0,0,32'h0,       0,0,2'b00,9'h000,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 1,32'hA1A1A1A1, PN ,1,1,32'h0,       1,0,2'b11,9'h010,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 0,0,            PID,0,1,32'hA1A1A1A1,1,0,2'b11,9'h010,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 0,0,            PDG,0,0,32'hA1A1A1A1,1,0,2'b11,9'h010,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 1,32'hB2B2B2B2, PN ,1,1,32'hA1A1A1A1,1,0,2'b11,9'h020,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 0,0,            PDD,0,1,32'hB2B2B2B2,0,0,2'b00,9'h000,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 0,0,            PIG,0,0,32'hB2B2B2B2,0,0,2'b00,9'h000,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 1,32'hC3C3C3C3, PN ,1,1,32'hB2B2B2B2,1,0,2'b11,9'h010,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 0,0,            PID,0,1,32'hC3C3C3C3,0,0,2'b00,9'h000,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 0,0,            PDG,0,0,32'hC3C3C3C3,0,0,2'b00,9'h000,0);
    add(1,9'h010,1,0,2'b11,9'h020,0, 1,32'hD4D4D4D4, PN ,1,1,32'hC3C3C3C3,1,0,2'b11,9'h020,0);
    add(0,9'h010,0,0,2'b11,9'h020,0, 0,0,            PDD,0,1,32'hD4D4D4D4,0,0,2'b00,9'h000,0);
    add(0,9'h000,0,0,2'b11,9'h000,0, 0,0,            PN ,0,0,32'hD4D4D4D4,0,0,2'b00,9'h000,0);
    add(1,9'h004,0,0,2'b11,9'h000,0, 0,0,            PIG,0,0,32'hD4D4D4D4,0,0,2'b00,9'h000,0);
    add(0,9'h004,0,0,2'b11,9'h000,0, 0,0,            PN ,1,1,32'hD4D4D4D4,1,0,2'b11,9'h004,0);
    add(0,9'h004,0,0,2'b11,9'h000,0, 0,0,            PN ,1,1,32'hD4D4D4D4,1,0,2'b11,9'h004,0);
    add(0,9'h004,0,0,2'b11,9'h000,0, 1,32'h2401000A, PN ,1,1,32'hD4D4D4D4,1,0,2'b11,9'h004,0);
    add(0,9'h004,0,0,2'b11,9'h000,0, 0,0,            PID,0,1,32'h2401000A,1,0,2'b11,9'h004,0);
    add(0,9'h000,0,0,2'b11,9'h000,0, 0,0,            PN ,0,0,32'h2401000A,1,0,2'b11,9'h004,0);
    add(0,9'h000,1,1,2'b01,9'h102,32'h0000BEEF, 0,0, PDG,0,0,32'h2401000A,0,0,2'b00,9'h000,0);
    add(0,9'h000,0,1,2'b01,9'h102,32'h0000BEEF, 1,32'hDEADDEAD,
        PN ,1,1,32'h2401000A,1,1,2'b01,9'h102,32'h0000BEEF);
    add(0,9'h000,0,0,2'b00,9'h000,0, 0,0,
        PDD,0,1,32'h2401000A,1,1,2'b01,9'h102,32'h0000BEEF);
    add(0,9'h000,0,0,2'b00,9'h000,0, 0,0,
        PN ,0,0,32'h2401000A,1,1,2'b01,9'h102,32'h0000BEEF);
    add(0,9'h000,1,0,2'b11,9'h003,0, 0,0,            PDG,0,0,32'h2401000A,0,0,2'b00,9'h000,0);
    add(0,9'h000,0,0,2'b11,9'h003,0, 1,32'h55555555, PDE,0,1,32'h2401000A,1,0,2'b11,9'h003,0);
    add(0,9'h000,1,0,2'b10,9'h100,0, 0,0,            PDG,0,0,32'h2401000A,0,0,2'b00,9'h000,0);
    add(0,9'h000,0,0,2'b10,9'h100,0, 1,32'h55555555, PDE,0,1,32'h2401000A,1,0,2'b10,9'h100,0);
    add(0,9'h000,0,0,2'b00,9'h000,0, 0,0,            PN ,0,0,32'h2401000A,0,0,2'b00,9'h000,0);

    reset = 1'b1;
    ifReq = 0; ifAddr = 0; dReq = 0; dRW = 0; dSize = 0; dAddr = 0; dWdata = 0;
    ramMFC = 0; ramDataOut = 0;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_pulses", pulses, PN);
    chk("rst_mfa", ramMFA, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ram", {ramRW, ramDataSize, ramAddress}, 0);
    chk("rst_din", ramDataIn, 0);
    @(negedge Clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      ifReq = vecs[i].ir; ifAddr = vecs[i].ia; dReq = vecs[i].dr; dRW = vecs[i].drw;
      dSize = vecs[i].dsz; dAddr = vecs[i].da; dWdata = vecs[i].dwd;
      ramMFC = vecs[i].mfc; ramDataOut = vecs[i].dout;
      #1;
      chk($sformatf("v%0d_pulses", i), pulses, vecs[i].pulse);
      chk($sformatf("v%0d_mfa", i), ramMFA, vecs[i].mfa);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rd);
      if (vecs[i].chk_ram) begin
        chk($sformatf("v%0d_rw", i), ramRW, vecs[i].rw);
        chk($sformatf("v%0d_size", i), ramDataSize, vecs[i].sz);
        chk($sformatf("v%0d_addr", i), ramAddress, vecs[i].addr);
        chk($sformatf("v%0d_din", i), ramDataIn, vecs[i].din);
      end
    end

    // MFC never arrives: MFA high for TIMEOUT cycles, then one dErr.
    @(negedge Clk);
    dReq = 1; dRW = 0; dSize = 2'b11; dAddr = 9'h040; ramMFC = 0; ramDataOut = 0;
    #1;
    chk("to_gnt", dGnt, 1);
    @(negedge Clk);
    dReq = 0;
    #1;
    seen = 0; prev_mfa = 0; mfa_cnt = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (i != 0) begin
        @(negedge Clk);
        #1;
      end
      if (dErr) begin
        seen = 1;
        chk("to_mfa_at_err", ramMFA, 0);
        chk("to_err_after_mfa", prev_mfa, 1);
      end
      if (ramMFA) mfa_cnt++;
      prev_mfa = ramMFA;
    end
    chk("to_err_seen", seen, 1);
    chk("to_mfa_cycles", mfa_cnt, 16);
    @(negedge Clk);
    ramMFC = 1; ramDataOut = 32'hFFFFFFFF;
    #1;
    chk("late_mfc_pulses", pulses, PN);
    chk("late_mfc_busy", busy, 0);
    chk("late_mfc_mfa", ramMFA, 0);
    @(negedge Clk);
    #1;
    chk("late_mfc_pulses2", pulses, PN);
    chk("late_mfc_rdata", rdata, 32'h2401000A);
    ramMFC = 0;

    // Reset mid-ACCESS after a fetch grant (lastGrant becomes FETCH before reset).
    @(negedge Clk);
    ifReq = 1; ifAddr = 9'h008;
    #1;
    chk("rma_gnt", ifGnt, 1);
    @(negedge Clk);
    ifReq = 0;
    #1;
    chk("rma_mfa_on", ramMFA, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rma_async_mfa", ramMFA, 0);
    chk("rma_async_busy", busy, 0);
    chk("rma_async_rdata", rdata, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      #1;
      chk($sformatf("rma_quiet%0d", i), pulses, PN);
    end
    reset = 1'b0;
    @(negedge Clk);
    ifReq = 1; ifAddr = 9'h00C; dReq = 1; dRW = 0; dSize = 2'b11; dAddr = 9'h020;
    #1;
    chk("rma_prio_pulses", pulses, PIG);
    @(negedge Clk);
    ifReq = 0; dReq = 0; ramMFC = 1; ramDataOut = 32'h12345678;
    #1;
    chk("rma_acc_mfa", ramMFA, 1);
    chk("rma_acc_addr", ramAddress, 9'h00C);
    @(negedge Clk);
    ramMFC = 0;
    #1;
    chk("rma_done", pulses, PID);
    chk("rma_rdata", rdata, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
